// File: rtl/usb_phy_pkg.sv
// Purpose: shared receive-path types and constants for the USB bit processor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usb_phy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        SYNC2,
        DATA,
        EOP
    } rx_state_t;

    // Consecutive decoded 1s after which the transmitter inserts a 0.
    localparam int unsigned STUFF_RUN = 6;

    localparam logic MODE_HS = 1'b1;
    localparam logic MODE_FS = 1'b0;

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// Purpose: NRZI decode of the selected line bit plus bit-stuff removal and stuff-violation detect.
// Latency: combinational outputs from the current sample; history/run registers update on bit_en.
// Backpressure: none; paced purely by bit_en, every strobe is consumed.
module usb_nrzi_unstuff
    import usb_phy_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic bit_en_i,
    input  logic mode_i,
    input  logic hs_bit_i,
    input  logic fs_bit_i,
    output logic dec_bit_o,
    output logic bit_out_en_o,
    output logic stuff_viol_o
);

    logic       line;
    logic       prev_line_q, prev_line_d;
    logic [2:0] ones_q, ones_d;
    logic       stuff_pos;

    assign line      = (mode_i == MODE_HS) ? hs_bit_i : fs_bit_i;
    assign dec_bit_o = (line == prev_line_q);
    // The bit after a full run of 1s is either a stuffed 0 (dropped) or a violation.
    assign stuff_pos    = (ones_q == 3'(STUFF_RUN));
    assign bit_out_en_o = bit_en_i & ~(stuff_pos & ~dec_bit_o);
    assign stuff_viol_o = bit_en_i & stuff_pos & dec_bit_o;

    // Track line history and the decoded-1 run length; run saturates at the stuff point.
    always_comb begin
        prev_line_d = prev_line_q;
        ones_d      = ones_q;
        if (bit_en_i) begin
            prev_line_d = line;
            if (!dec_bit_o) begin
                ones_d = '0;
            end else if (!stuff_pos) begin
                ones_d = ones_q + 3'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prev_line_q <= 1'b1;
            ones_q      <= '0;
        end else begin
            prev_line_q <= prev_line_d;
            ones_q      <= ones_d;
        end
    end

endmodule

// File: rtl/usb_rx_bitproc.sv
// Purpose: UTMI-style receive bit processor: SYNC hunt, unstuffed byte/word assembly, EOP/abort/babble handling.
// Latency: rx_valid/rx_error/rx_active update on the clock edge that samples the deciding bit_en.
// Backpressure: none; the link controller must accept every rx_valid strobe.
module usb_rx_bitproc
    import usb_phy_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_MIN_HS = 12,
    parameter int SYNC_MIN_FS = 5,
    parameter int MAX_PKT     = 1027,
    parameter int CNT_W       = 11
) (
    input  logic              clk_480m_usb,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              speed_select,
    input  logic              hs_bit_phy,
    input  logic              fs_bit_phy,
    input  logic              se_dp,
    input  logic              se_dm,
    input  logic              squelch,
    input  logic              tx_enable,
    output logic              rx_active,
    output logic              rx_valid,
    output logic              rx_valid_h,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_error,
    output logic [CNT_W-1:0]  rx_byte_cnt
);

    localparam bit WIDE = (DATA_W == 16);

    rx_state_t         state_q, state_d;
    logic [4:0]        zcnt_q, zcnt_d;
    logic [7:0]        byte_q, byte_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [7:0]        lo_q, lo_d;
    logic              half_q, half_d;
    logic              active_q, active_d;
    logic              valid_q, valid_d;
    logic              valid_h_q, valid_h_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       dec_bit, bit_out_en, stuff_viol;
    logic       is_hs, se0, line_abort, end_clean;
    logic [4:0] sync_min;
    logic [7:0] byte_next;

    usb_nrzi_unstuff u_nrzi (
        .clk_i        (clk_480m_usb),
        .rst_n_i      (rst_n),
        .bit_en_i     (bit_en),
        .mode_i       (speed_select),
        .hs_bit_i     (hs_bit_phy),
        .fs_bit_i     (fs_bit_phy),
        .dec_bit_o    (dec_bit),
        .bit_out_en_o (bit_out_en),
        .stuff_viol_o (stuff_viol)
    );

    assign is_hs      = (speed_select == MODE_HS);
    assign se0        = ~se_dp & ~se_dm;
    // Loss of signal: squelch in HS, SE0 in FS.
    assign line_abort = is_hs ? squelch : se0;
    assign sync_min   = is_hs ? 5'(SYNC_MIN_HS) : 5'(SYNC_MIN_FS);
    assign byte_next  = {dec_bit, byte_q[7:1]};

    // Receive FSM, byte/word assembly and strobe generation.
    always_comb begin
        state_d   = state_q;
        zcnt_d    = zcnt_q;
        byte_d    = byte_q;
        ptr_d     = ptr_q;
        lo_d      = lo_q;
        half_d    = half_q;
        active_d  = active_q;
        valid_d   = 1'b0;
        valid_h_d = 1'b0;
        data_d    = data_q;
        error_d   = 1'b0;
        cnt_d     = cnt_q;
        end_clean = 1'b0;
        if (tx_enable) begin
            state_d  = IDLE;
            active_d = 1'b0;
        end else if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!line_abort) begin
                        state_d = HUNT;
                        zcnt_d  = '0;
                    end
                end
                HUNT: begin
                    if (line_abort) begin
                        state_d = IDLE;
                    end else if (!dec_bit) begin
                        if (zcnt_q != 5'd31) zcnt_d = zcnt_q + 5'd1;
                    end else if (zcnt_q >= sync_min) begin
                        state_d = SYNC2;
                    end else begin
                        zcnt_d = '0;
                    end
                end
                SYNC2: begin
                    if (line_abort) begin
                        state_d = IDLE;
                    end else if (dec_bit) begin
                        state_d  = DATA;
                        active_d = 1'b1;
                        cnt_d    = '0;
                        ptr_d    = '0;
                        half_d   = 1'b0;
                    end else begin
                        state_d = HUNT;
                        zcnt_d  = 5'd1;
                    end
                end
                DATA: begin
                    if (line_abort) begin
                        // FS SE0 on a byte boundary is a clean end; anything else aborts.
                        state_d  = EOP;
                        active_d = 1'b0;
                        if (!is_hs && ptr_q == 3'd0) end_clean = 1'b1;
                        else                         error_d   = 1'b1;
                    end else if (stuff_viol) begin
                        // HS EOP is signalled by a stuff violation; in FS it is an error.
                        state_d  = EOP;
                        active_d = 1'b0;
                        if (is_hs) end_clean = 1'b1;
                        else       error_d   = 1'b1;
                    end else if (bit_out_en) begin
                        byte_d = byte_next;
                        ptr_d  = ptr_q + 3'd1;
                        if (ptr_q == 3'd7) begin
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_q == CNT_W'(MAX_PKT)) begin
                                error_d  = 1'b1;
                                state_d  = EOP;
                                active_d = 1'b0;
                            end else if (!WIDE) begin
                                valid_d = 1'b1;
                                data_d  = DATA_W'(byte_next);
                            end else if (half_q) begin
                                valid_d   = 1'b1;
                                valid_h_d = 1'b1;
                                data_d    = DATA_W'({byte_next, lo_q});
                                half_d    = 1'b0;
                            end else begin
                                lo_d   = byte_next;
                                half_d = 1'b1;
                            end
                        end
                    end
                end
                EOP: begin
                    if (is_hs ? squelch : (!se0 && fs_bit_phy)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // A clean end flushes a pending odd low byte as a half word.
            if (end_clean && WIDE && half_q) begin
                valid_d   = 1'b1;
                valid_h_d = 1'b0;
                data_d    = DATA_W'({8'h00, lo_q});
                half_d    = 1'b0;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_480m_usb) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            zcnt_q    <= '0;
            byte_q    <= '0;
            ptr_q     <= '0;
            lo_q      <= '0;
            half_q    <= 1'b0;
            active_q  <= 1'b0;
            valid_q   <= 1'b0;
            valid_h_q <= 1'b0;
            data_q    <= '0;
            error_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            zcnt_q    <= zcnt_d;
            byte_q    <= byte_d;
            ptr_q     <= ptr_d;
            lo_q      <= lo_d;
            half_q    <= half_d;
            active_q  <= active_d;
            valid_q   <= valid_d;
            valid_h_q <= valid_h_d;
            data_q    <= data_d;
            error_q   <= error_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rx_active   = active_q;
    assign rx_valid    = valid_q;
    assign rx_valid_h  = valid_h_q;
    assign rx_data     = data_q;
    assign rx_error    = error_q;
    assign rx_byte_cnt = cnt_q;

endmodule
